pid_pwm: RTL and testbench

Downstream stage of the PID controller. It consumes the signed controller output and drives an H-bridge with two complementary-direction PWM outputs.
- The command is sampled once per PWM period and converted to magnitude (duty) and sign (direction).
- Dead-time is inserted on every direction reversal.
- A one-cycle sample strobe marks each period boundary, so the PID stage can be advanced in lock-step with the PWM.

---
 rtl/pid_pkg.sv | 23 ++
 rtl/pid_pwm.sv | 142 ++++++++++++++
 tb/tb_pid_pwm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID controller and its PWM back end.
package pid_pkg;

    localparam int PID_D_WIDTH = 32;
    localparam int SAT_W       = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        DEAD = 2'd3
    } pwm_state_t;

    // Magnitude of a sign-extended two's-complement value, clamped to limit.
    // Negation is done in unsigned arithmetic so the most-negative value cannot overflow.
    function automatic logic [SAT_W-1:0] sat_mag(input logic signed [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0]        limit);
        logic [SAT_W-1:0] mag;
        mag = value[SAT_W-1] ? (~value + SAT_W'(1)) : value;
        return (mag > limit) ? limit : mag;
    endfunction

endpackage

// File: rtl/pid_pwm.sv
// H-bridge PWM stage: samples the signed PID command once per period, drives two
// direction legs with dead-time on reversal, and strobes each period boundary.
module pid_pwm
    import pid_pkg::*;
#(
    parameter int D_WIDTH     = PID_D_WIDTH,
    parameter int CNT_WIDTH   = 16,
    parameter int PERIOD      = 100,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [D_WIDTH-1:0]   cmd,
    output logic                        pwm_a,
    output logic                        pwm_b,
    output logic                        dir,
    output logic                        sample_strobe,
    output logic [CNT_WIDTH-1:0]        duty_q,
    output logic [1:0]                  state_dbg
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] DEAD_INIT = CNT_WIDTH'(DEAD_CYCLES - 1);

    pwm_state_t             r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_dead_cnt;
    logic [CNT_WIDTH-1:0]   r_duty;
    logic                   r_dir;
    logic                   r_pwm_a;
    logic                   r_pwm_b;
    logic                   r_strobe;

    pwm_state_t             w_state_nxt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [CNT_WIDTH-1:0]   w_dead_nxt;
    logic [CNT_WIDTH-1:0]   w_duty_nxt;
    logic                   w_dir_nxt;
    logic                   w_pwm_a_nxt;
    logic                   w_pwm_b_nxt;
    logic                   w_strobe_nxt;

    logic signed [SAT_W-1:0] w_cmd_ext;
    logic [CNT_WIDTH-1:0]   w_mag;
    logic                   w_new_dir;
    logic                   w_at_end;
    logic                   w_load;
    logic                   w_reverse;

    assign w_cmd_ext = SAT_W'(cmd);
    assign w_mag     = CNT_WIDTH'(sat_mag(w_cmd_ext, SAT_W'(PERIOD)));
    assign w_new_dir = cmd[D_WIDTH-1];
    assign w_at_end  = (r_cnt == LAST_CNT);
    assign w_load    = (r_state == IDLE) || ((r_state != IDLE) && w_at_end);
    // A zero command carries no direction, so it never counts as a reversal.
    assign w_reverse = (w_mag != '0) && (w_new_dir != r_dir);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dead_cnt <= '0;
            r_duty     <= '0;
            r_dir      <= 1'b0;
            r_pwm_a    <= 1'b0;
            r_pwm_b    <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_duty     <= w_duty_nxt;
            r_dir      <= w_dir_nxt;
            r_pwm_a    <= w_pwm_a_nxt;
            r_pwm_b    <= w_pwm_b_nxt;
            r_strobe   <= w_strobe_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dead_nxt   = r_dead_cnt;
        w_duty_nxt   = r_duty;
        w_dir_nxt    = r_dir;
        w_pwm_a_nxt  = 1'b0;
        w_pwm_b_nxt  = 1'b0;
        w_strobe_nxt = 1'b0;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            w_pwm_a_nxt  = (r_state == FWD) && (r_cnt < r_duty);
            w_pwm_b_nxt  = (r_state == REV) && (r_cnt < r_duty);
            w_strobe_nxt = (r_state != IDLE) && w_at_end;
            if (r_state != IDLE) begin
                w_cnt_nxt = w_at_end ? '0 : r_cnt + CNT_WIDTH'(1);
            end
            if (w_load) begin
                w_duty_nxt = w_mag;
            end
            case (r_state)
                IDLE: begin
                    // Outputs are already low, so start driving without a dead gap.
                    if (w_mag != '0) begin
                        w_dir_nxt = w_new_dir;
                    end
                    w_state_nxt = (((w_mag != '0) ? w_new_dir : r_dir)) ? REV : FWD;
                end
                FWD, REV: begin
                    if (w_load && w_reverse) begin
                        w_state_nxt = DEAD;
                        w_dead_nxt  = DEAD_INIT;
                        w_dir_nxt   = w_new_dir;
                    end
                end
                DEAD: begin
                    if (w_load && w_reverse) begin
                        w_dead_nxt = DEAD_INIT;
                        w_dir_nxt  = w_new_dir;
                    end else if (r_dead_cnt == '0) begin
                        w_state_nxt = r_dir ? REV : FWD;
                    end else begin
                        w_dead_nxt = r_dead_cnt - CNT_WIDTH'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign pwm_a         = r_pwm_a;
    assign pwm_b         = r_pwm_b;
    assign dir           = r_dir;
    assign sample_strobe = r_strobe;
    assign duty_q        = r_duty;
    assign state_dbg     = r_state;

    ap_legs_exclusive: assert property (@(posedge clock) disable iff (!reset) !(r_pwm_a && r_pwm_b));

endmodule

// File: tb/tb_pid_pwm.sv
// Directed bench for pid_pwm: vector table of per-period commands plus hand
// sequences for enable drop/re-enable and asynchronous reset during dead-time.
module tb_pid_pwm;
    import pid_pkg::*;

    localparam int D_WIDTH     = 32;
    localparam int CNT_WIDTH   = 16;
    localparam int PERIOD      = 100;
    localparam int DEAD_CYCLES = 4;
    localparam int NV          = 12;

    logic                      clock;
    logic                      reset;
    logic                      enable;
    logic signed [D_WIDTH-1:0] cmd;
    logic                      pwm_a;
    logic                      pwm_b;
    logic                      dir;
    logic                      sample_strobe;
    logic [CNT_WIDTH-1:0]      duty_q;
    logic [1:0]                state_dbg;

    int checks;
    int errors;

    typedef struct {
        logic signed [D_WIDTH-1:0] cmd;
        logic [CNT_WIDTH-1:0]      duty;
        logic                      dir;
        pwm_state_t                st;
        int                        a_hi;
        int                        b_hi;
        int                        dead;
    } vec_t;

    vec_t vecs[NV];

    pid_pwm #(
        .D_WIDTH(D_WIDTH),
        .CNT_WIDTH(CNT_WIDTH),
        .PERIOD(PERIOD),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .cmd(cmd),
        .pwm_a(pwm_a),
        .pwm_b(pwm_b),
        .dir(dir),
        .sample_strobe(sample_strobe),
        .duty_q(duty_q),
        .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sample_strobe && n < 3 * PERIOD);
        check(name, longint'(sample_strobe), 1);
    endtask

    // Dead cycles are counted from the current cycle; outputs from the next one,
    // because the legs are registered one cycle behind the counter.
    task automatic measure(input string tag, input int exp_a, input int exp_b, input int exp_dead);
        int na, nb, nd, ns;
        na = 0; nb = 0; nd = 0; ns = 0;
        for (int i = 0; i <= PERIOD; i++) begin
            if (i > 0) begin
                na += int'(pwm_a);
                nb += int'(pwm_b);
                ns += int'(sample_strobe);
            end
            if (i < PERIOD) begin
                if (state_dbg == DEAD) nd++;
                @(negedge clock);
            end
        end
        check({tag, "_a_high"}, na, exp_a);
        check({tag, "_b_high"}, nb, exp_b);
        check({tag, "_dead"}, nd, exp_dead);
        check({tag, "_strobes"}, ns, 1);
        check({tag, "_strobe_end"}, longint'(sample_strobe), 1);
    endtask

    always @(negedge clock) begin
        if (pwm_a && pwm_b) begin
            errors++;
            $display("FAIL legs_exclusive: got pwm_a=%0b pwm_b=%0b required not both 1", pwm_a, pwm_b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time %0t required finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [CNT_WIDTH-1:0] prev_duty;
        logic                 prev_dir;
        int                   n_hi;
        int                   n_st;

        vecs[0]  = '{cmd: -25,            duty: 25,  dir: 1'b1, st: DEAD, a_hi: 0,   b_hi: 21,  dead: 4};
        vecs[1]  = '{cmd: 0,              duty: 0,   dir: 1'b1, st: REV,  a_hi: 0,   b_hi: 0,   dead: 0};
        vecs[2]  = '{cmd: 10,             duty: 10,  dir: 1'b0, st: DEAD, a_hi: 6,   b_hi: 0,   dead: 4};
        vecs[3]  = '{cmd: 150,            duty: 100, dir: 1'b0, st: FWD,  a_hi: 100, b_hi: 0,   dead: 0};
        vecs[4]  = '{cmd: 32'sh8000_0000, duty: 100, dir: 1'b1, st: DEAD, a_hi: 0,   b_hi: 96,  dead: 4};
        vecs[5]  = '{cmd: 32'sh8000_0000, duty: 100, dir: 1'b1, st: REV,  a_hi: 0,   b_hi: 100, dead: 0};
        vecs[6]  = '{cmd: 150,            duty: 100, dir: 1'b0, st: DEAD, a_hi: 96,  b_hi: 0,   dead: 4};
        vecs[7]  = '{cmd: 100,            duty: 100, dir: 1'b0, st: FWD,  a_hi: 100, b_hi: 0,   dead: 0};
        vecs[8]  = '{cmd: 1,              duty: 1,   dir: 1'b0, st: FWD,  a_hi: 1,   b_hi: 0,   dead: 0};
        vecs[9]  = '{cmd: -1,             duty: 1,   dir: 1'b1, st: DEAD, a_hi: 0,   b_hi: 0,   dead: 4};
        vecs[10] = '{cmd: -99,            duty: 99,  dir: 1'b1, st: REV,  a_hi: 0,   b_hi: 99,  dead: 0};
        vecs[11] = '{cmd: 40,             duty: 40,  dir: 1'b0, st: DEAD, a_hi: 36,  b_hi: 0,   dead: 4};

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        enable = 1'b1;
        cmd    = 40;

        repeat (3) @(negedge clock);
        check("rst_pwm_a", longint'(pwm_a), 0);
        check("rst_pwm_b", longint'(pwm_b), 0);
        check("rst_dir", longint'(dir), 0);
        check("rst_strobe", longint'(sample_strobe), 0);
        check("rst_duty", longint'(duty_q), 0);
        check("rst_state", longint'(state_dbg), longint'(IDLE));

        // First load happens on the first edge out of IDLE.
        reset = 1'b1;
        @(negedge clock);
        check("init_state", longint'(state_dbg), longint'(FWD));
        check("init_duty", longint'(duty_q), 40);
        check("init_dir", longint'(dir), 0);
        check("init_strobe", longint'(sample_strobe), 0);
        measure("init", 40, 0, 0);
        prev_duty = 40;
        prev_dir  = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cmd = vecs[i].cmd;
            repeat (30) @(negedge clock);
            check($sformatf("v%0d_shadow_duty", i), longint'(duty_q), longint'(prev_duty));
            check($sformatf("v%0d_shadow_state", i), longint'(state_dbg),
                  longint'(prev_dir ? REV : FWD));
            wait_strobe($sformatf("v%0d_strobe_seen", i));
            check($sformatf("v%0d_duty", i), longint'(duty_q), longint'(vecs[i].duty));
            check($sformatf("v%0d_dir", i), longint'(dir), longint'(vecs[i].dir));
            check($sformatf("v%0d_state", i), longint'(state_dbg), longint'(vecs[i].st));
            measure($sformatf("v%0d", i), vecs[i].a_hi, vecs[i].b_hi, vecs[i].dead);
            prev_duty = vecs[i].duty;
            prev_dir  = vecs[i].dir;
        end

        // Enable dropped mid-pulse at cnt=10 with duty 40.
        repeat (10) @(negedge clock);
        check("en_pre_pwm_a", longint'(pwm_a), 1);
        enable = 1'b0;
        @(negedge clock);
        check("en_off_pwm_a", longint'(pwm_a), 0);
        check("en_off_state", longint'(state_dbg), longint'(IDLE));
        check("en_off_duty", longint'(duty_q), 40);
        check("en_off_dir", longint'(dir), 0);
        n_hi = 0;
        n_st = 0;
        repeat (150) begin
            @(negedge clock);
            n_hi += int'(pwm_a) + int'(pwm_b);
            n_st += int'(sample_strobe);
        end
        check("en_off_pwm_highs", n_hi, 0);
        check("en_off_strobes", n_st, 0);

        // Re-enable: immediate load, straight to REV with no dead gap, cnt from 0.
        cmd    = -30;
        enable = 1'b1;
        @(negedge clock);
        check("reen_state", longint'(state_dbg), longint'(REV));
        check("reen_duty", longint'(duty_q), 30);
        check("reen_dir", longint'(dir), 1);
        check("reen_strobe", longint'(sample_strobe), 0);
        measure("reen", 0, 30, 0);

        // Reverse twice to land in DEAD with dir=1, then reset asynchronously.
        cmd = 20;
        wait_strobe("rdead_strobe1");
        check("rdead_state1", longint'(state_dbg), longint'(DEAD));
        cmd = -50;
        wait_strobe("rdead_strobe2");
        check("rdead_state2", longint'(state_dbg), longint'(DEAD));
        check("rdead_dir2", longint'(dir), 1);
        check("rdead_duty2", longint'(duty_q), 50);
        reset = 1'b0;
        #1;
        check("arst_pwm_a", longint'(pwm_a), 0);
        check("arst_pwm_b", longint'(pwm_b), 0);
        check("arst_dir", longint'(dir), 0);
        check("arst_strobe", longint'(sample_strobe), 0);
        check("arst_duty", longint'(duty_q), 0);
        check("arst_state", longint'(state_dbg), longint'(IDLE));

        enable = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_state", longint'(state_dbg), longint'(IDLE));
        check("post_strobe", longint'(sample_strobe), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
